four_and_three_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 8 +
 rtl/full_adder.sv | 11 +
 rtl/four_and_three_multiplier.sv | 100 ++++++++++
 tb/tb_four_and_three_multiplier.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and product type for the 3x4 array multiplier
package mult_pkg;
    localparam int A_W = 3;
    localparam int B_W = 4;
    localparam int C_W = A_W + B_W;

    typedef logic [C_W-1:0] product_t;
endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell of the multiplier array
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/four_and_three_multiplier.sv
// rtl/four_and_three_multiplier.sv - unsigned 3x4 AND/adder-array multiplier, registered output
// FOUR_AND_THREE_MULT_PIPE_EN adds a register after the first adder row (latency 2).
module four_and_three_multiplier
    import mult_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    input  logic           in_valid,
    output product_t       C,
    output logic           out_valid
);
    logic [A_W-1:0] pp      [B_W];
    logic [A_W-1:0] row_hi  [1:B_W-1];
    logic [A_W-1:0] row_pp  [1:B_W-1];
    logic [A_W:0]   row_out [1:B_W-1];
    logic [1:0]     low_bits;
    logic           res_valid;
    product_t       product;

    always_comb begin
        for (int j = 0; j < B_W; j++) begin
            pp[j] = A & {A_W{B[j]}};
        end
    end

    // Each row adds its pp terms to the running sum shifted down by one; bit 0 retires a product bit.
    generate
        for (genvar j = 1; j < B_W; j++) begin : g_row
            logic [A_W:0]   carry;
            logic [A_W-1:0] sum;
            assign carry[0] = 1'b0;
            for (genvar i = 0; i < A_W; i++) begin : g_bit
                full_adder u_fa (
                    .a   (row_hi[j][i]),
                    .b   (row_pp[j][i]),
                    .cin (carry[i]),
                    .s   (sum[i]),
                    .cout(carry[i+1])
                );
            end
            assign row_out[j] = {carry[A_W], sum};
        end
    endgenerate

    assign row_hi[1] = {1'b0, pp[0][A_W-1:1]};
    assign row_pp[1] = pp[1];
    assign row_hi[3] = row_out[2][A_W:1];

`ifdef FOUR_AND_THREE_MULT_PIPE_EN
    logic [A_W-1:0] s1_hi;
    logic [A_W-1:0] s1_pp2;
    logic [A_W-1:0] s1_pp3;
    logic [1:0]     s1_low;
    logic           s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hi    <= '0;
            s1_pp2   <= '0;
            s1_pp3   <= '0;
            s1_low   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_hi    <= row_out[1][A_W:1];
            s1_pp2   <= pp[2];
            s1_pp3   <= pp[3];
            s1_low   <= {row_out[1][0], pp[0][0]};
            s1_valid <= in_valid;
        end
    end

    assign row_hi[2] = s1_hi;
    assign row_pp[2] = s1_pp2;
    assign row_pp[3] = s1_pp3;
    assign low_bits  = s1_low;
    assign res_valid = s1_valid;
`else
    assign row_hi[2] = row_out[1][A_W:1];
    assign row_pp[2] = pp[2];
    assign row_pp[3] = pp[3];
    assign low_bits  = {row_out[1][0], pp[0][0]};
    assign res_valid = in_valid;
`endif

    assign product = {row_out[3], row_out[2][0], low_bits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= res_valid;
            if (res_valid) begin
                C <= product;
            end
        end
    end
endmodule

// File: tb/tb_four_and_three_multiplier.sv
// tb/tb_four_and_three_multiplier.sv - directed self-checking bench for four_and_three_multiplier
module tb_four_and_three_multiplier;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [6:0] c;
    logic       out_valid;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FOUR_AND_THREE_MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    four_and_three_multiplier dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a),
        .B        (b),
        .in_valid (in_valid),
        .C        (c),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle in_valid pulse, then flush so the product sits on C with out_valid high.
    task automatic load_and_check(input string tag, input logic [2:0] av, input logic [3:0] bv,
                                  input logic [6:0] exp);
        a = av; b = bv; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (LAT - 1) step();
        check({tag, "_c"}, 32'(c), 32'(exp));
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        int ia;
        int ib;
        rst_n = 1'b0; a = 3'd7; b = 4'd15; in_valid = 1'b1;
        #1;
        check("rst_async_c", 32'(c), 32'd0);
        check("rst_async_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_hold_c", 32'(c), 32'd0);
            check("rst_hold_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 32'(out_valid), 32'd0);

        load_and_check("dir_5x12", 3'b101, 4'b1100, 7'b0111100);
        load_and_check("dir_4x1", 3'b100, 4'b0001, 7'b0000100);
        load_and_check("corner_0x15", 3'd0, 4'd15, 7'd0);
        load_and_check("corner_7x15", 3'd7, 4'd15, 7'b1101001);
        load_and_check("corner_1x1", 3'd1, 4'd1, 7'd1);

        // Reset mid-stream: outputs must clear before any clock edge.
        load_and_check("pre_rst_5x12", 3'd5, 4'd12, 7'd60);
        a = 3'd6; b = 4'd9; in_valid = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_async_c", 32'(c), 32'd0);
        check("midrst_async_valid", 32'(out_valid), 32'd0);
        step();
        check("midrst_hold_c", 32'(c), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (LAT) step();
        check("midrst_flushed_c", 32'(c), 32'd0);
        check("midrst_flushed_valid", 32'(out_valid), 32'd0);

        load_and_check("hold_load", 3'd5, 4'd12, 7'd60);
        for (int k = 0; k < 3; k++) begin
            a = 3'(k + 1); b = 4'(k * 5 + 3);
            step();
            check("hold_c", 32'(c), 32'd60);
            check("hold_valid", 32'(out_valid), 32'd0);
        end

        // Stream all 128 combinations; after pushing index n, index n-(LAT-1) is on C.
        for (int n = 0; n < 128 + LAT - 1; n++) begin
            if (n < 128) begin
                a = n[2:0]; b = n[6:3]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (n >= LAT - 1) begin
                ia = (n - (LAT - 1)) % 8;
                ib = (n - (LAT - 1)) / 8;
                check("stream_c", 32'(c), 32'(ia * ib));
                check("stream_valid", 32'(out_valid), 32'd1);
            end
        end
        in_valid = 1'b0;
        repeat (LAT) step();
        check("stream_end_valid", 32'(out_valid), 32'd0);
        check("stream_end_c", 32'(c), 32'd105);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
